fp_mul_sched: RTL and testbench
===============================

# fp_mul_sched

Round-robin scheduler that shares one combinational `fp_mul` instance between NREQ requesters, such as FP issue slots or the FMUL path and a divide/sqrt iteration engine. It arbitrates valid/ready requests, registers the winning operands into the shared multiplier, and captures the product into a result register. It returns the product with the requester id and an invalid-operation flag over a backpressured response port. It sits between the FP issue logic and the `fp_mul` datapath and instantiates `fp_mul` internally.

## Interface
- NREQ, 2, number of requesters (2..8)
- IDW, 1, requester id width; must equal clog2(NREQ), minimum 1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  32*NREQ  operand A, requester i at [32*i+31:32*i]
- req_b  in  32*NREQ  operand B, same packing
- flush  in  1  synchronous kill of the in-flight operation
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  IDW  index of the requester that owns the result
- resp_p  out  32  IEEE-754 single product
- resp_nv  out  1  invalid-operation flag
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - grant = first requester with req_valid=1, searching ptr+1, ptr+2, … modulo NREQ.
  - req_ready[grant] = 1 only when some req_valid is set and flush=0; all other bits are 0.
  - On handshake: latch req_a/req_b of grant into op_a/op_b, latch grant into id_q, set ptr←grant, go to EXEC.
- **EXEC**
  - op_a/op_b drive the shared `fp_mul`.
  - Capture its product into resp_p.
  - Compute nv from op_a/op_b and capture into resp_nv.
  - Go to RESP.
- **RESP**
  - resp_valid=1; resp_id/resp_p/resp_nv are held stable.
  - If resp_ready=1, go to IDLE.
  - No new request is accepted in this cycle.
- **nv rule.** resp_nv = 1 when either of the following holds:
  - either operand is sNaN (exp=0xFF, frac≠0, frac[22]=0);
  - the operands are inf×zero (exp=0xFF with frac=0, times exp=0 with frac=0), in either order.
  - Otherwise resp_nv = 0.
  - qNaN operands do not set nv.
- **Arbitration fairness.** ptr updates only on handshake, so any continuously asserted requester is granted within NREQ accepted operations.
- **flush**
  - In IDLE: blocks the handshake; all req_ready=0.
  - In EXEC or RESP: return to IDLE next edge, clear resp_valid, no response is produced; ptr is kept.
  - flush takes priority over resp_ready in the same cycle.
- **Requester rules.** Requesters keep req_valid and operands stable until ready; the block does not check this. Dropping req_valid before the grant is allowed and simply removes that requester from the arbitration.

## Timing
- Reset values (async, immediate): state=IDLE, ptr=NREQ-1 (requester 0 wins first), op_a=op_b=0, id_q=0, resp_p=0, resp_nv=0, resp_valid=0, busy=0, req_ready=0.
- The handshake edge is T0. EXEC occupies cycle T0+1, and resp_valid is high from the edge ending that cycle (visible in cycle T0+2).
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with resp_ready=1). Each cycle resp_ready is held low adds one cycle.
- req_ready is combinational from req_valid, state, ptr and flush. resp_* are registered outputs only.
- The `fp_mul` combinational path runs op register → result register in one cycle, with no combinational input-to-output path.
- Reset asserted mid-operation: the response is lost and all outputs take reset values immediately.

## Test plan
- **Single op.** Req0 a=0x40000000 (2.0), b=0x40400000 (3.0) → resp_valid two cycles after handshake, resp_p=0x40C00000, resp_id=0, resp_nv=0.
- **Invalid, inf×zero.** a=0x7F800000, b=0x00000000 → resp_p=0x7F80002A, resp_nv=1. Sub-case a=0x7F800001 (sNaN), b=0x3F800000 → resp_p=0x7F800001, resp_nv=1. Sub-case a=0x7FC00000 (qNaN) → resp_nv=0.
- **Contention.** NREQ=2, both valid continuously for 4 ops → grant order 0,1,0,1; never two req_ready bits high at once.
- **Backpressure.** Hold resp_ready=0 for 5 cycles in RESP → resp_valid/resp_p/resp_id stay stable and req_ready stays 0. Releasing resp_ready returns to IDLE next edge.
- **Flush.**
  - Assert flush in EXEC → no resp_valid, IDLE next cycle.
  - Assert flush together with resp_ready in RESP → resp_valid drops and no second response appears.
  - Assert flush in IDLE with req_valid=1 → req_ready=0 that cycle.
- **Reset mid-op.** Drop rst_n in RESP → resp_valid=0 and busy=0 immediately. After release, the first grant goes to requester 0 even when all requesters are valid.

Source files
------------

// File: rtl/fp_mul_sched_if.sv
// rtl/fp_mul_sched_if.sv - request/response bundle between FP issue logic and the shared multiplier scheduler
interface fp_mul_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               flush;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_p;
  logic               resp_nv;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, flush, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_p, resp_nv, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, flush, resp_ready,
    output req_ready, resp_valid, resp_id, resp_p, resp_nv, busy
  );
endinterface

// File: rtl/fp_mul_sched.sv
// rtl/fp_mul_sched.sv - round-robin scheduler sharing one combinational single-precision multiplier
// Combinational IEEE-754 single multiply, round-to-nearest-even.
// Subnormal inputs and underflowing results flush to signed zero.
// A NaN operand is returned unchanged (a before b); inf x exact zero
// yields the fixed default NaN 0x7F80002A.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  logic              sign;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_s, exp_r;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  // Unpack, multiply significands, normalise, round and pick special cases
  always_comb begin
    sign     = a[31] ^ b[31];
    ea       = a[30:23];
    eb       = b[30:23];
    fa       = a[22:0];
    fb       = b[22:0];
    nan_a    = (ea == 8'hFF) && (fa != 23'd0);
    nan_b    = (eb == 8'hFF) && (fb != 23'd0);
    inf_a    = (ea == 8'hFF) && (fa == 23'd0);
    inf_b    = (eb == 8'hFF) && (fb == 23'd0);
    zero_a   = (ea == 8'h00) && (fa == 23'd0);
    zero_b   = (eb == 8'h00) && (fb == 23'd0);
    prod     = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    mant     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    // A rounding carry leaves the fraction all-zero and bumps the exponent
    exp_r    = exp_s + $signed({9'd0, mant_r[23]});
    p        = {sign, exp_r[7:0], mant_r[22:0]};

    if (nan_a) begin
      p = a;
    end else if (nan_b) begin
      p = b;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      p = 32'h7F80002A;
    end else if (inf_a || inf_b) begin
      p = {sign, 8'hFF, 23'd0};
    end else if ((ea == 8'h00) || (eb == 8'h00)) begin
      p = {sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      p = {sign, 8'hFF, 23'd0};
    end else if (exp_r <= 10'sd0) begin
      p = {sign, 31'd0};
    end
  end
endmodule

module fp_mul_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_mul_sched_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  id_q;
  logic            any_valid;
  logic            hs;
  logic [NREQ-1:0] ready;
  logic [31:0]     op_a, op_b;
  logic [31:0]     mul_p;
  logic [31:0]     resp_p_q;
  logic            resp_nv_q;
  logic            resp_valid_q;
  logic            nv;

  function automatic logic is_snan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0) && !x[22];
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any_valid && bus.req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  // Accept only in IDLE, never while flush is asserted, one-hot on the grant
  always_comb begin
    ready = '0;
    hs    = (state == S_IDLE) && any_valid && !bus.flush;
    if (hs) begin
      ready[grant] = 1'b1;
    end
  end

  fp_mul u_fp_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_p)
  );

  assign nv = is_snan(op_a) || is_snan(op_b) ||
              (is_inf(op_a) && is_zero(op_b)) ||
              (is_zero(op_a) && is_inf(op_b));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: flush aborts EXEC/RESP and wins over resp_ready
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hs) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = bus.flush ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (bus.flush || bus.resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on handshake; pointer moves only when a request is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= IDW'(NREQ - 1);
      op_a <= '0;
      op_b <= '0;
      id_q <= '0;
    end else if (hs) begin
      ptr  <= grant;
      op_a <= bus.req_a[int'(grant)*32 +: 32];
      op_b <= bus.req_b[int'(grant)*32 +: 32];
      id_q <= grant;
    end
  end

  // Result register: load from the multiplier in EXEC, release on consume or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_p_q     <= '0;
      resp_nv_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else if (state == S_EXEC && !bus.flush) begin
      resp_p_q     <= mul_p;
      resp_nv_q    <= nv;
      resp_valid_q <= 1'b1;
    end else if (state == S_RESP && (bus.flush || bus.resp_ready)) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_p     = resp_p_q;
  assign bus.resp_nv    = resp_nv_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_fp_mul_sched.sv
// tb/tb_fp_mul_sched.sv - scoreboard bench for fp_mul_sched
module tb_fp_mul_sched;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    p;
    logic           nv;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        nv;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fp_mul_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fp_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one-hot ready every cycle, scoreboard pop on each consumed response
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("ready_onehot", 32'($countones(bus.req_ready) > 1), 32'd0);
      if (bus.resp_valid && bus.resp_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_id", 32'(bus.resp_id), 32'(e.id));
          check("resp_p",  bus.resp_p, e.p);
          check("resp_nv", 32'(bus.resp_nv), 32'(e.nv));
        end
      end
    end
  end

  // Raise a request, wait for its grant, optionally register the expected response
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ep, input logic env, input bit push);
    bit   ok;
    exp_t e;
    bus.req_a[32*idx +: 32] = a;
    bus.req_b[32*idx +: 32] = b;
    bus.req_valid[idx] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_timeout", 32'(ok), 32'd1);
    if (ok && push) begin
      e.id = IDW'(idx);
      e.p  = ep;
      e.nv = env;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (sb.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 32'(ok), 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    bit ok;
    logic [IDW-1:0] g;
    exp_t e;

    vecs[0] = '{32'h7F800000, 32'h00000000, 32'h7F80002A, 1'b1};
    vecs[1] = '{32'h7F800001, 32'h3F800000, 32'h7F800001, 1'b1};
    vecs[2] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0};
    vecs[3] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0};
    vecs[4] = '{32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0};
    vecs[5] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0};
    vecs[6] = '{32'h00000000, 32'hFF800000, 32'h7F80002A, 1'b1};
    vecs[7] = '{32'h3F800000, 32'hFF800005, 32'hFF800005, 1'b1};
    vecs[8] = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 1'b0};

    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_p",     bus.resp_p, 32'd0);
    check("rst_resp_nv",    32'(bus.resp_nv), 32'd0);
    check("rst_resp_id",    32'(bus.resp_id), 32'd0);
    check("rst_busy",       32'(bus.busy), 32'd0);
    check("rst_req_ready",  32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op with latency check
    issue(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_exec_valid", 32'(bus.resp_valid), 32'd0);
    check("lat_exec_busy",  32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_resp_valid", 32'(bus.resp_valid), 32'd1);
    drain();

    // Directed vectors, alternating requesters
    for (int i = 0; i < 9; i++) begin
      issue(i % 2, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nv, 1'b1);
      drain();
    end

    // Backpressure: 5 stalled cycles in RESP with requester 1 waiting
    bus.resp_ready = 1'b0;
    issue(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.req_a[63:32] = 32'h3F800000;
    bus.req_b[63:32] = 32'h3F800000;
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_p",     bus.resp_p, 32'h40400000);
      check("bp_id",    32'(bus.resp_id), 32'd0);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready), 32'd2);
    if (bus.req_ready[1]) begin
      e.id = 1'b1;
      e.p  = 32'h3F800000;
      e.nv = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    drain();

    // Flush in EXEC
    issue(0, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flx_valid", 32'(bus.resp_valid), 32'd0);
      check("flx_busy",  32'(bus.busy), 32'd0);
    end
    @(posedge clk);
    #1;

    // Flush together with resp_ready in RESP
    bus.resp_ready = 1'b0;
    issue(1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.flush      = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("flr_pre_valid", 32'(bus.resp_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flr_valid", 32'(bus.resp_valid), 32'd0);
      check("flr_busy",  32'(bus.busy), 32'd0);
    end
    @(posedge clk);
    #1;

    // Flush in IDLE blocks the handshake
    bus.req_a[31:0]  = 32'h40400000;
    bus.req_b[31:0]  = 32'h40400000;
    bus.req_valid[0] = 1'b1;
    bus.flush        = 1'b1;
    @(negedge clk);
    check("fli_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fli_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    issue(0, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b1);
    drain();

    // Reset in RESP: outputs clear immediately, response lost
    bus.resp_ready = 1'b0;
    issue(1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rmo_pre_valid", 32'(bus.resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmo_valid", 32'(bus.resp_valid), 32'd0);
    check("rmo_busy",  32'(bus.busy), 32'd0);
    check("rmo_p",     bus.resp_p, 32'd0);
    check("rmo_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus.resp_ready = 1'b1;

    // Contention after reset: grant order 0,1,0,1
    bus.req_a[31:0]  = 32'h40000000;
    bus.req_b[31:0]  = 32'h40400000;
    bus.req_a[63:32] = 32'h3F800000;
    bus.req_b[63:32] = 32'hC0000000;
    bus.req_valid    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.req_ready != '0) begin
          ok = 1'b1;
          break;
        end
      end
      check("cont_timeout", 32'(ok), 32'd1);
      if (ok) begin
        g = bus.req_ready[1];
        check("cont_grant", 32'(g), 32'(i % 2));
        e.id = g;
        e.p  = g ? 32'hC0000000 : 32'h40C00000;
        e.nv = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
